// File: rtl/stack_ptr_bank_if.sv
// Operation/status bundle for stack_ptr_bank: the master issues per-cycle stack
// operations and the slave (the pointer bank) returns pointers and status flags.
interface stack_ptr_bank_if #(
    parameter int WIDTH      = 16,
    parameter int NUM_STACKS = 2,
    parameter int SEL_W      = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1
);
    logic [SEL_W-1:0]            Sel;
    logic                        Push;
    logic                        Pop;
    logic                        Load;
    logic [WIDTH-1:0]            LoadData;
    logic                        ClearErr;
    logic [NUM_STACKS*WIDTH-1:0] SPOut;
    logic [WIDTH-1:0]            TopAddr;
    logic [WIDTH-1:0]            PushAddr;
    logic [NUM_STACKS-1:0]       Full;
    logic [NUM_STACKS-1:0]       Empty;
    logic [NUM_STACKS-1:0]       Overflow;
    logic [NUM_STACKS-1:0]       Underflow;

    modport master (
        output Sel, Push, Pop, Load, LoadData, ClearErr,
        input  SPOut, TopAddr, PushAddr, Full, Empty, Overflow, Underflow
    );

    modport slave (
        input  Sel, Push, Pop, Load, LoadData, ClearErr,
        output SPOut, TopAddr, PushAddr, Full, Empty, Overflow, Underflow
    );
endinterface

// File: rtl/stack_ptr_bank.sv
// Bank of independent full-stack pointers with per-stack entry counts, growth
// direction, sticky overflow/underflow flags, and one operation per cycle on stack Sel.
module stack_ptr_bank #(
    parameter int                          WIDTH      = 16,
    parameter int                          NUM_STACKS = 2,
    parameter int                          DEPTH      = 256,
    parameter int                          STEP       = 1,
    parameter logic [NUM_STACKS*WIDTH-1:0] RESET_BASE = '0,
    parameter logic [NUM_STACKS-1:0]       GROW_DOWN  = '0
) (
    input logic              CLK,
    input logic              RegReset,
    stack_ptr_bank_if.slave  bus
);
    localparam int SEL_W = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [WIDTH-1:0]      sp_q    [NUM_STACKS];
    logic [WIDTH-1:0]      sp_d    [NUM_STACKS];
    logic [CNT_W-1:0]      count_q [NUM_STACKS];
    logic [CNT_W-1:0]      count_d [NUM_STACKS];
    logic [NUM_STACKS-1:0] ovf_q, ovf_d, ovf_set;
    logic [NUM_STACKS-1:0] unf_q, unf_d, unf_set;
    logic [NUM_STACKS-1:0] full, empty;

    logic             sel_valid;
    logic [SEL_W-1:0] sel_idx;

    // Out-of-range selects only exist when NUM_STACKS is not a power of two.
    generate
        if (NUM_STACKS == (1 << SEL_W)) begin : g_sel_full
            assign sel_valid = 1'b1;
        end else begin : g_sel_part
            assign sel_valid = (bus.Sel < SEL_W'(NUM_STACKS));
        end
    endgenerate

    assign sel_idx = sel_valid ? bus.Sel : '0;

    always_comb begin
        for (int i = 0; i < NUM_STACKS; i++) begin
            full[i]  = (count_q[i] == DEPTH_C);
            empty[i] = (count_q[i] == '0);
        end
    end

    // Per-stack next state; only the selected stack can change.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        ovf_set = '0;
        unf_set = '0;
        for (int i = 0; i < NUM_STACKS; i++) begin
            sp_d[i]    = sp_q[i];
            count_d[i] = count_q[i];
            if (sel_valid && (bus.Sel == SEL_W'(i))) begin
                if (bus.Load) begin
                    sp_d[i]    = bus.LoadData;
                    count_d[i] = '0;
                end else if (bus.Push && bus.Pop) begin
                    // Top replace: pointer and count stay, but an empty stack has no top.
                    unf_set[i] = empty[i];
                end else if (bus.Push) begin
                    if (full[i]) begin
                        ovf_set[i] = 1'b1;
                    end else begin
                        sp_d[i]    = GROW_DOWN[i] ? (sp_q[i] - STEP_W) : (sp_q[i] + STEP_W);
                        count_d[i] = count_q[i] + ONE_C;
                    end
                end else if (bus.Pop) begin
                    if (empty[i]) begin
                        unf_set[i] = 1'b1;
                    end else begin
                        sp_d[i]    = GROW_DOWN[i] ? (sp_q[i] + STEP_W) : (sp_q[i] - STEP_W);
                        count_d[i] = count_q[i] - ONE_C;
                    end
                end
            end
        end
    end

    // A clear and a fresh error in the same cycle leave the flag set.
    assign ovf_d = bus.ClearErr ? ovf_set : (ovf_q | ovf_set);
    assign unf_d = bus.ClearErr ? unf_set : (unf_q | unf_set);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RegReset) begin
            for (int i = 0; i < NUM_STACKS; i++) begin
                sp_q[i]    <= RESET_BASE[i*WIDTH +: WIDTH];
                count_q[i] <= '0;
            end
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_STACKS; i++) begin
                sp_q[i]    <= sp_d[i];
                count_q[i] <= count_d[i];
            end
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_comb begin
        bus.SPOut = '0;
        for (int i = 0; i < NUM_STACKS; i++) begin
            bus.SPOut[i*WIDTH +: WIDTH] = sp_q[i];
        end
    end

    assign bus.TopAddr   = sp_q[sel_idx];
    assign bus.PushAddr  = GROW_DOWN[sel_idx] ? (sp_q[sel_idx] - STEP_W)
                                              : (sp_q[sel_idx] + STEP_W);
    assign bus.Full      = full;
    assign bus.Empty     = empty;
    assign bus.Overflow  = ovf_q;
    assign bus.Underflow = unf_q;

endmodule

// File: tb/tb_stack_ptr_bank.sv
// Directed table-driven bench for stack_ptr_bank: stack 0 grows down from 0x0100,
// stack 1 grows up from 0xFFFE, DEPTH=4.
module tb_stack_ptr_bank;
    localparam int WIDTH = 16;
    localparam int NS    = 2;

    logic CLK = 1'b0;
    logic RegReset;

    always #5 CLK = ~CLK;

    stack_ptr_bank_if #(.WIDTH(WIDTH), .NUM_STACKS(NS)) bus ();

    stack_ptr_bank #(
        .WIDTH      (WIDTH),
        .NUM_STACKS (NS),
        .DEPTH      (4),
        .STEP       (1),
        .RESET_BASE ({16'hFFFE, 16'h0100}),
        .GROW_DOWN  (2'b01)
    ) dut (
        .CLK      (CLK),
        .RegReset (RegReset),
        .bus      (bus.slave)
    );

    typedef struct {
        logic        sel;
        logic        push;
        logic        pop;
        logic        load;
        logic [15:0] load_data;
        logic        clr;
        logic [15:0] exp_sp0;
        logic [15:0] exp_sp1;
        logic [1:0]  exp_full;
        logic [1:0]  exp_empty;
        logic [1:0]  exp_ovf;
        logic [1:0]  exp_unf;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic sel, input logic push, input logic pop,
                         input logic load, input logic [15:0] data, input logic clr);
        bus.Sel      = sel;
        bus.Push     = push;
        bus.Pop      = pop;
        bus.Load     = load;
        bus.LoadData = data;
        bus.ClearErr = clr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [15:0] sp0, input logic [15:0] sp1,
                               input logic [1:0] full, input logic [1:0] empty,
                               input logic [1:0] ovf, input logic [1:0] unf);
        check({tag, ".SPOut"},     32'(bus.SPOut),     {sp1, sp0});
        check({tag, ".Full"},      32'(bus.Full),      32'(full));
        check({tag, ".Empty"},     32'(bus.Empty),     32'(empty));
        check({tag, ".Overflow"},  32'(bus.Overflow),  32'(ovf));
        check({tag, ".Underflow"}, 32'(bus.Underflow), 32'(unf));
    endtask

    initial begin
        //          sel push pop load data     clr  sp0       sp1       full   empty  ovf    unf
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FF, 16'hFFFE, 2'b00, 2'b10, 2'b00, 2'b00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FE, 16'hFFFE, 2'b00, 2'b10, 2'b00, 2'b00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FD, 16'hFFFE, 2'b00, 2'b10, 2'b00, 2'b00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FC, 16'hFFFE, 2'b01, 2'b10, 2'b00, 2'b00};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FC, 16'hFFFE, 2'b01, 2'b10, 2'b01, 2'b00};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FC, 16'hFFFF, 2'b01, 2'b00, 2'b01, 2'b00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FC, 16'h0000, 2'b01, 2'b00, 2'b01, 2'b00};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FC, 16'h0001, 2'b01, 2'b00, 2'b01, 2'b00};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h00FC, 16'h0001, 2'b01, 2'b00, 2'b01, 2'b00};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h2000, 1'b0, 16'h00FC, 16'h2000, 2'b01, 2'b10, 2'b01, 2'b00};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h00FC, 16'h2000, 2'b01, 2'b10, 2'b01, 2'b10};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00FC, 16'h2000, 2'b01, 2'b10, 2'b01, 2'b00};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00FC, 16'h2000, 2'b01, 2'b10, 2'b00, 2'b00};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h00FD, 16'h2000, 2'b00, 2'b10, 2'b00, 2'b00};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h00FD, 16'h2000, 2'b00, 2'b10, 2'b00, 2'b10};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h1234, 16'h2000, 2'b00, 2'b11, 2'b00, 2'b10};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h2000, 2'b00, 2'b11, 2'b00, 2'b11};

        // Reset while a push is requested: reset must win.
        RegReset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        RegReset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        check_state("reset", 16'h0100, 16'hFFFE, 2'b00, 2'b11, 2'b00, 2'b00);

        check("top_sel0",  32'(bus.TopAddr),  32'h0100);
        check("push_sel0", 32'(bus.PushAddr), 32'h00FF);
        bus.Sel = 1'b1;
        #1;
        check("top_sel1",  32'(bus.TopAddr),  32'hFFFE);
        check("push_sel1", 32'(bus.PushAddr), 32'hFFFF);

        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].sel, vecs[v].push, vecs[v].pop, vecs[v].load, vecs[v].load_data, vecs[v].clr);
            tick();
            check_state($sformatf("vec%0d", v), vecs[v].exp_sp0, vecs[v].exp_sp1,
                        vecs[v].exp_full, vecs[v].exp_empty, vecs[v].exp_ovf, vecs[v].exp_unf);
        end

        // Push onto stack 1 (grows up) at 0x2000, then check its next push address.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        check("top_after_push1",  32'(bus.TopAddr),  32'h2001);
        check("push_after_push1", 32'(bus.PushAddr), 32'h2002);

        // Load concurrent with reset: every stack returns to its reset base.
        RegReset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        tick();
        RegReset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        #1;
        check_state("load_reset", 16'h0100, 16'hFFFE, 2'b00, 2'b11, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/stack_ptr_bank.md
STACK_PTR_BANK -- requirements
Module: stack_ptr_bank

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 16, giving the pointer and address width in bits.
REQ-002 The block SHALL have a parameter NUM_STACKS, default 2, giving the number of independent stack pointers (legal range 1..8).
REQ-003 The block SHALL have a parameter DEPTH, default 256, giving the maximum entries per stack (legal range 1..2^WIDTH-1).
REQ-004 The block SHALL have a parameter STEP, default 1, giving the address increment per entry.
REQ-005 The block SHALL have a parameter RESET_BASE, NUM_STACKS*WIDTH bits, giving the reset pointer of stack i in slice i.
REQ-006 The block SHALL have a parameter GROW_DOWN, NUM_STACKS bits, where bit i=1 means stack i push decrements its pointer.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-008 CLK  in  1  rising-edge clock.
REQ-009 RegReset  in  1  synchronous active-high reset.
REQ-010 Sel  in  max(1,clog2(NUM_STACKS))  stack addressed by this cycle's operation.
REQ-011 Push, Pop, Load  in  1 each  operation strobes applied to stack Sel.
REQ-012 LoadData  in  WIDTH  new pointer value for Load.
REQ-013 ClearErr  in  1  clears all sticky error flags.
REQ-014 SPOut  out  NUM_STACKS*WIDTH  registered pointer of every stack, stack i in slice i.
REQ-015 TopAddr, PushAddr  out  WIDTH  combinational: pointer of stack Sel, and the address the next push to stack Sel will occupy.
REQ-016 Full, Empty, Overflow, Underflow  out  NUM_STACKS each  per-stack status; Overflow and Underflow are sticky.

Function
REQ-017 Pointer semantics SHALL be full-stack: SP addresses the current top entry.
REQ-018 Each stack SHALL keep an entry counter Count_i in 0..DEPTH; Empty_i SHALL equal (Count_i==0) and Full_i SHALL equal (Count_i==DEPTH).
REQ-019 PushAddr SHALL equal SP_Sel-STEP when GROW_DOWN[Sel]=1, otherwise SP_Sel+STEP, computed modulo 2^WIDTH.
REQ-020 A Push alone on a non-full stack SHALL set SP to PushAddr and increment Count on the next rising edge.
REQ-021 A Pop alone on a non-empty stack SHALL move SP by STEP opposite to the growth direction and decrement Count.
REQ-022 A Push on a full stack SHALL leave SP and Count unchanged and set Overflow_Sel.
REQ-023 A Pop on an empty stack SHALL leave SP and Count unchanged and set Underflow_Sel.
REQ-024 Push and Pop asserted together SHALL be a top replace: SP and Count unchanged, no error if Count>0, Underflow_Sel set if Count==0.
REQ-025 Load SHALL take priority over Push and Pop; it SHALL set SP_Sel to LoadData and Count_Sel to 0 and leave error flags unchanged.
REQ-026 Stacks not equal to Sel SHALL hold all state in that cycle.
REQ-027 All pointer arithmetic SHALL wrap modulo 2^WIDTH with no flag raised; only Count governs full and empty.
REQ-028 ClearErr SHALL clear every Overflow and Underflow bit; a new error set in the same cycle SHALL win, so the bit reads 1.
REQ-029 All state updates SHALL take one cycle; status outputs SHALL derive from registered state only.
REQ-030 A Sel value of NUM_STACKS or greater SHALL make Push, Pop and Load no-ops.

Reset
REQ-031 While RegReset=1 at a rising edge, every SP_i SHALL load RESET_BASE slice i, Count_i SHALL load 0, and Overflow and Underflow SHALL load 0.
REQ-032 RegReset SHALL override every concurrent strobe, including a Load or Push in the same cycle.
REQ-033 After reset, Empty SHALL be all ones and Full SHALL be all zeros.

Verification
Bench parameters: WIDTH=16, NUM_STACKS=2, DEPTH=4, STEP=1, RESET_BASE={16'hFFFE,16'h0100}, GROW_DOWN=2'b01.
REQ-034 Reset pulse -> SP0=0x0100, SP1=0xFFFE, Empty=2'b11, Full=2'b00, Overflow=Underflow=2'b00.
REQ-035 Five Push on Sel=0 -> SP0 goes 0x00FF, 0x00FE, 0x00FD, 0x00FC; Full0=1 after the 4th push; the 5th push leaves SP0=0x00FC and sets Overflow0=1; SP1 is unchanged throughout.
REQ-036 Three Push on Sel=1 -> SP1 goes 0xFFFF, 0x0000, 0x0001, wrapping with no error.
REQ-037 Push+Pop on full stack 0 -> SP0 stays 0x00FC with no new error; then Pop on empty stack 1 after Load LoadData=0x2000 -> SP1=0x2000 and Underflow1=1.
REQ-038 ClearErr and an overflowing Push in the same cycle -> Overflow0 reads 1; Load and RegReset in the same cycle -> SP returns to RESET_BASE.
